syzygy_adc_frame_gen: RTL and testbench

Parallel-side transmitter for the SYZYGY ADC serial link, used as a loopback/emulation source for the ADC receive path. Each `slow_clk` cycle it produces one 8-bit frame word and two 8-bit data-lane words, ready for an external OSERDESE3 (8:1) per lane. It runs a training sequence, then streams samples. A programmable bit offset emulates lane misalignment so the receive-side bitslip logic can be exercised with known answers.

---
 rtl/syzygy_adc_frame_gen_pkg.sv | 29 ++
 rtl/syzygy_adc_frame_gen_if.sv | 15 +
 rtl/syzygy_adc_frame_gen_word_rotate.sv | 44 ++++
 rtl/syzygy_adc_frame_gen.sv | 200 ++++++++++++++++++++
 tb/tb_syzygy_adc_frame_gen.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/syzygy_adc_frame_gen_pkg.sv
// Shared definitions for the SYZYGY ADC frame generator.
// Contents: FSM state enum, lane width, FIFO depth, default frame pattern,
// and the {prev, cur} bit-rotation helper used by every output stream.
package syzygy_adc_pkg;

    localparam int LANE_W     = 8;
    localparam int FIFO_DEPTH = 2;

    localparam logic [LANE_W-1:0] FRAME_WORD_DEF = 8'hF0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TRAIN = 2'd1,
        ST_RUN   = 2'd2
    } state_e;

    // Emulated lane misalignment: the output word straddles the previous and
    // current words, i.e. {prev[off-1:0], cur[7:off]}; off = 0 passes cur.
    function automatic logic [LANE_W-1:0] rot_word(
        input logic [LANE_W-1:0] prev,
        input logic [LANE_W-1:0] cur,
        input logic [2:0]        off
    );
        logic [2*LANE_W-1:0] cat;
        cat = {prev, cur} >> off;
        return cat[LANE_W-1:0];
    endfunction

endpackage

// File: rtl/syzygy_adc_frame_gen_if.sv
// Sample stream into the frame generator.
// master: drives s_data/s_valid, receives s_ready (sample source).
// slave : receives s_data/s_valid, drives s_ready (the frame generator).
// s_data[15:8] feeds lane 0, s_data[7:0] feeds lane 1.
interface syzygy_adc_frame_gen_if;
    import syzygy_adc_pkg::*;

    logic [2*LANE_W-1:0] s_data;
    logic                s_valid;
    logic                s_ready;

    modport master (output s_data, output s_valid, input s_ready);
    modport slave  (input s_data, input s_valid, output s_ready);

endinterface

// File: rtl/syzygy_adc_frame_gen_word_rotate.sv
// word_rotate: registered 8-bit rotator over {prev, cur}.
// Ports: clk, reset (sync, active high), clr (zero prev and output),
//        offset (bit shift 0-7), cur_i (current word), out_q (rotated word).
// prev is the cur_i seen on the previous clock, so out_q lags cur_i by one edge.
module word_rotate
    import syzygy_adc_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic [2:0]        offset,
    input  logic [LANE_W-1:0] cur_i,
    output logic [LANE_W-1:0] out_q
);

    logic [LANE_W-1:0] prev_q;
    logic [LANE_W-1:0] prev_d;
    logic [LANE_W-1:0] out_d;

    // Next prev/output; clr zeroes both so a fresh burst starts from prev = 0.
    always_comb begin
        prev_d = '0;
        out_d  = '0;
        if (clr) begin
            prev_d = '0;
            out_d  = '0;
        end else begin
            prev_d = cur_i;
            out_d  = rot_word(prev_q, cur_i, offset);
        end
    end

    // Rotator registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q <= '0;
            out_q  <= '0;
        end else begin
            prev_q <= prev_d;
            out_q  <= out_d;
        end
    end

endmodule

// File: rtl/syzygy_adc_frame_gen.sv
// syzygy_adc_frame_gen: parallel-side SYZYGY ADC link transmitter.
// Ports: slow_clk, reset (sync, active high), ena, bit_offset (latched on
//        leaving IDLE), train_len, s_if (sample stream, slave side),
//        frame_q/lane0_q/lane1_q (8-bit words to OSERDES, MSB first),
//        tx_active, training, underflow_count.
// Pipeline: stage 1 selects the current 24-bit word {frame, lane0, lane1}
// from the FSM/FIFO; stage 2 rotates it against the previous word.
module syzygy_adc_frame_gen
    import syzygy_adc_pkg::*;
#(
    parameter logic [2*LANE_W-1:0] TRAIN_WORD = 16'hA55A,
    parameter logic [2*LANE_W-1:0] IDLE_WORD  = 16'h0000,
    parameter logic [LANE_W-1:0]   FRAME_WORD = FRAME_WORD_DEF
)(
    input  logic                     slow_clk,
    input  logic                     reset,
    input  logic                     ena,
    input  logic [2:0]               bit_offset,
    input  logic [7:0]               train_len,
    syzygy_adc_frame_gen_if.slave    s_if,
    output logic [LANE_W-1:0]        frame_q,
    output logic [LANE_W-1:0]        lane0_q,
    output logic [LANE_W-1:0]        lane1_q,
    output logic                     tx_active,
    output logic                     training,
    output logic [7:0]               underflow_count
);

    state_e              state_q, state_d;
    logic [2:0]          off_q, off_d;
    logic [7:0]          tcnt_q, tcnt_d;
    logic [7:0]          uf_q, uf_d;
    logic [3*LANE_W-1:0] cur_q, cur_d;
    logic                cur_act_q, cur_act_d;
    logic                cur_trn_q, cur_trn_d;
    logic                tx_active_q;
    logic                training_q;

    logic [2*LANE_W-1:0] fifo_q [FIFO_DEPTH];
    logic [2*LANE_W-1:0] fifo_d [FIFO_DEPTH];
    logic                wr_ptr_q, wr_ptr_d;
    logic                rd_ptr_q, rd_ptr_d;
    logic [1:0]          cnt_q, cnt_d;

    logic                push_s;
    logic                pop_s;
    logic                clr_rot_s;

    assign s_if.s_ready    = (cnt_q < 2'd2);
    assign push_s          = s_if.s_valid & s_if.s_ready;
    assign clr_rot_s       = (state_q == ST_IDLE);
    assign tx_active       = tx_active_q;
    assign training        = training_q;
    assign underflow_count = uf_q;

    // FSM next state and stage-1 word select.
    always_comb begin
        state_d   = state_q;
        off_d     = off_q;
        tcnt_d    = tcnt_q;
        uf_d      = uf_q;
        cur_d     = '0;
        cur_act_d = 1'b0;
        cur_trn_d = 1'b0;
        pop_s     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ena) begin
                    off_d   = bit_offset;
                    tcnt_d  = train_len;
                    uf_d    = 8'd0;
                    state_d = (train_len == 8'd0) ? ST_RUN : ST_TRAIN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_TRAIN: begin
                if (!ena) begin
                    state_d = ST_IDLE;
                end else begin
                    cur_d     = {FRAME_WORD, TRAIN_WORD};
                    cur_act_d = 1'b1;
                    cur_trn_d = 1'b1;
                    tcnt_d    = tcnt_q - 8'd1;
                    state_d   = (tcnt_q == 8'd1) ? ST_RUN : ST_TRAIN;
                end
            end
            ST_RUN: begin
                if (!ena) begin
                    state_d = ST_IDLE;
                end else begin
                    cur_act_d = 1'b1;
                    if (cnt_q != 2'd0) begin
                        pop_s = 1'b1;
                        cur_d = {FRAME_WORD, fifo_q[rd_ptr_q]};
                    end else begin
                        cur_d = {FRAME_WORD, IDLE_WORD};
                        uf_d  = (uf_q == 8'hFF) ? uf_q : uf_q + 8'd1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Two-entry FIFO bookkeeping; ena low flushes (and drops any push).
    // The pop decision uses cnt_q, so a push into an empty FIFO is popped
    // one cycle later.
    always_comb begin
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (!ena) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            cnt_d    = 2'd0;
        end else begin
            if (push_s) begin
                fifo_d[wr_ptr_q] = s_if.s_data;
                wr_ptr_d         = ~wr_ptr_q;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = ~rd_ptr_q;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            cnt_d = cnt_q + {1'b0, push_s} - {1'b0, pop_s};
        end
    end

    // State, counters, FIFO and stage-1 registers; stage-2 status flags.
    always_ff @(posedge slow_clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            off_q       <= 3'd0;
            tcnt_q      <= 8'd0;
            uf_q        <= 8'd0;
            cur_q       <= '0;
            cur_act_q   <= 1'b0;
            cur_trn_q   <= 1'b0;
            tx_active_q <= 1'b0;
            training_q  <= 1'b0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            cnt_q       <= 2'd0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            off_q       <= off_d;
            tcnt_q      <= tcnt_d;
            uf_q        <= uf_d;
            cur_q       <= cur_d;
            cur_act_q   <= cur_act_d;
            cur_trn_q   <= cur_trn_d;
            tx_active_q <= cur_act_q;
            training_q  <= cur_trn_q;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_q[i] <= fifo_d[i];
            end
        end
    end

    word_rotate u_rot_frame (
        .clk    (slow_clk),
        .reset  (reset),
        .clr    (clr_rot_s),
        .offset (off_q),
        .cur_i  (cur_q[3*LANE_W-1:2*LANE_W]),
        .out_q  (frame_q)
    );

    word_rotate u_rot_lane0 (
        .clk    (slow_clk),
        .reset  (reset),
        .clr    (clr_rot_s),
        .offset (off_q),
        .cur_i  (cur_q[2*LANE_W-1:LANE_W]),
        .out_q  (lane0_q)
    );

    word_rotate u_rot_lane1 (
        .clk    (slow_clk),
        .reset  (reset),
        .clr    (clr_rot_s),
        .offset (off_q),
        .cur_i  (cur_q[LANE_W-1:0]),
        .out_q  (lane1_q)
    );

endmodule

// File: tb/tb_syzygy_adc_frame_gen.sv
// Scoreboard bench for syzygy_adc_frame_gen: a behavioural model pushes each
// expected output word when it is produced; a negedge monitor pops and
// compares whenever the DUT shows tx_active. Directed checks cover the
// training patterns, rotation constants, streaming, backpressure and resets.
module tb_syzygy_adc_frame_gen;

    logic       slow_clk = 1'b0;
    logic       reset    = 1'b1;
    logic       ena      = 1'b0;
    logic [2:0] bit_offset = 3'd0;
    logic [7:0] train_len  = 8'd0;
    logic [7:0] frame_q, lane0_q, lane1_q, underflow_count;
    logic       tx_active, training;

    syzygy_adc_frame_gen_if sif ();

    syzygy_adc_frame_gen dut (
        .slow_clk        (slow_clk),
        .reset           (reset),
        .ena             (ena),
        .bit_offset      (bit_offset),
        .train_len       (train_len),
        .s_if            (sif),
        .frame_q         (frame_q),
        .lane0_q         (lane0_q),
        .lane1_q         (lane1_q),
        .tx_active       (tx_active),
        .training        (training),
        .underflow_count (underflow_count)
    );

    initial forever #5 slow_clk = ~slow_clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [7:0] f;
        logic [7:0] l0;
        logic [7:0] l1;
        logic       trn;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] fifo_m[$];
    int          m_mode = 0;   // 0 idle, 1 training, 2 running
    int          m_left = 0;
    int          m_off  = 0;
    int          m_uf   = 0;
    logic [23:0] m_last = 24'd0;

    function automatic logic [7:0] rot(input logic [7:0] p, input logic [7:0] c, input int off);
        int t;
        t = (int'(p) * 256 + int'(c)) >> off;
        return t[7:0];
    endfunction

    initial forever begin
        bit          accept;
        bit          prod;
        bit          trn;
        logic [23:0] w;
        exp_t        e;
        @(posedge slow_clk);
        if (reset) begin
            m_mode = 0; m_off = 0; m_uf = 0; m_left = 0; m_last = 24'd0;
            fifo_m.delete();
            sb.delete();
        end else begin
            prod = 1'b0; trn = 1'b0; w = 24'd0;
            accept = sif.s_valid && (fifo_m.size() < 2) && ena;
            if (m_mode == 0) begin
                if (ena) begin
                    m_off  = int'(bit_offset);
                    m_uf   = 0;
                    m_left = int'(train_len);
                    m_mode = (train_len == 8'd0) ? 2 : 1;
                end
            end else if (!ena) begin
                m_mode = 0;
            end else if (m_mode == 1) begin
                prod = 1'b1; trn = 1'b1;
                w = {8'hF0, 16'hA55A};
                m_left--;
                if (m_left == 0) m_mode = 2;
            end else begin
                prod = 1'b1;
                if (fifo_m.size() > 0) begin
                    w = {8'hF0, fifo_m.pop_front()};
                end else begin
                    w = {8'hF0, 16'h0000};
                    if (m_uf < 255) m_uf++;
                end
            end
            if (!ena) fifo_m.delete();
            else if (accept) fifo_m.push_back(sif.s_data);
            if (prod) begin
                e.f   = rot(m_last[23:16], w[23:16], m_off);
                e.l0  = rot(m_last[15:8],  w[15:8],  m_off);
                e.l1  = rot(m_last[7:0],   w[7:0],   m_off);
                e.trn = trn;
                sb.push_back(e);
                m_last = w;
            end else begin
                m_last = 24'd0;
            end
        end
    end

    // ---------------- monitor ----------------
    initial forever begin
        exp_t e;
        @(negedge slow_clk);
        if (tx_active) begin
            if (sb.size() == 0) begin
                total++; bad++;
                $display("FAIL sb_word: DUT word %0h with no expected word queued", {frame_q, lane0_q, lane1_q});
            end else begin
                e = sb.pop_front();
                check("sb_word", 32'({frame_q, lane0_q, lane1_q, training}), 32'({e.f, e.l0, e.l1, e.trn}));
            end
        end else begin
            check("idle_zero", 32'({frame_q, lane0_q, lane1_q, training}), 32'd0);
        end
        check("s_ready", 32'(sif.s_ready), 32'(fifo_m.size() < 2));
        check("uf_count", 32'(underflow_count), 32'(m_uf));
    end

    // ---------------- stimulus ----------------
    task automatic step(input int n);
        repeat (n) @(negedge slow_clk);
    endtask

    task automatic wait_tx(input int maxc);
        for (int i = 0; i < maxc; i++) begin
            @(negedge slow_clk);
            if (tx_active) return;
        end
        total++; bad++;
        $display("FAIL wait_tx: tx_active still 0 after %0d cycles, expected 1", maxc);
    endtask

    initial begin
        sif.s_valid = 1'b0;
        sif.s_data  = 16'd0;
        step(3);
        check("rst_out",   32'({frame_q, lane0_q, lane1_q, tx_active, training}), 32'd0);
        check("rst_ready", 32'(sif.s_ready), 32'd1);
        check("rst_uf",    32'(underflow_count), 32'd0);
        reset = 1'b0;

        // training, no offset
        train_len = 8'd4; bit_offset = 3'd0; ena = 1'b1;
        wait_tx(8);
        for (int i = 0; i < 4; i++) begin
            check("trn0_word", 32'({frame_q, lane0_q, lane1_q, training}), 32'({8'hF0, 8'hA5, 8'h5A, 1'b1}));
            step(1);
        end
        check("trn0_end", 32'({tx_active, training}), 32'd2);
        step(3);

        // training with offset 3; later offset changes must be ignored
        ena = 1'b0; step(2);
        bit_offset = 3'd3; train_len = 8'd8; ena = 1'b1;
        step(1);
        bit_offset = 3'd6;
        wait_tx(8);
        check("off3_first_f",  32'(frame_q), 32'h1E);
        check("off3_first_l0", 32'(lane0_q), 32'h14);
        step(1);
        check("off3_f",  32'(frame_q), 32'h1E);
        check("off3_l0", 32'(lane0_q), 32'hB4);
        check("off3_l1", 32'(lane1_q), 32'h4B);
        step(8);

        // streaming straight into RUN
        ena = 1'b0; step(2);
        bit_offset = 3'd0; train_len = 8'd0; ena = 1'b1;
        sif.s_valid = 1'b1; sif.s_data = 16'h1234; step(1);
        sif.s_data = 16'h5678; step(1);
        sif.s_valid = 1'b0;
        wait_tx(4);
        check("stream_w0", 32'({lane0_q, lane1_q}), 32'h1234);
        check("stream_uf0", 32'(underflow_count), 32'd0);
        step(1);
        check("stream_w1", 32'({lane0_q, lane1_q}), 32'h5678);
        step(300);
        check("uf_sat", 32'(underflow_count), 32'd255);

        // backpressure during training, then in-order drain in RUN
        ena = 1'b0; step(2);
        train_len = 8'd10; ena = 1'b1;
        sif.s_valid = 1'b1; sif.s_data = 16'($urandom); step(1);
        sif.s_data = 16'($urandom); step(1);
        check("bp_ready", 32'(sif.s_ready), 32'd0);
        for (int i = 0; i < 20; i++) begin
            sif.s_data = 16'($urandom); step(1);
        end

        // ena drop with FIFO full, then re-enable with offset 5
        ena = 1'b0; step(2);
        train_len = 8'd10; ena = 1'b1; step(3);
        check("full_ready", 32'(sif.s_ready), 32'd0);
        ena = 1'b0; step(1);
        check("drop_ready", 32'(sif.s_ready), 32'd1);
        step(1);
        check("drop_out", 32'({frame_q, lane0_q, lane1_q, tx_active}), 32'd0);
        sif.s_valid = 1'b0;
        bit_offset = 3'd5; train_len = 8'd6; ena = 1'b1;
        wait_tx(8);
        step(1);
        check("off5_frame", 32'(frame_q), 32'h87);
        for (int i = 0; i < 40; i++) begin
            sif.s_valid = 1'($urandom_range(0, 1));
            sif.s_data  = 16'($urandom);
            bit_offset  = 3'($urandom);
            step(1);
        end

        // reset in the middle of RUN
        sif.s_valid = 1'b1; step(3);
        reset = 1'b1; step(1);
        check("mid_rst_out",   32'({frame_q, lane0_q, lane1_q, tx_active, training}), 32'd0);
        check("mid_rst_ready", 32'(sif.s_ready), 32'd1);
        check("mid_rst_uf",    32'(underflow_count), 32'd0);
        reset = 1'b0;

        // random episodes
        for (int ep = 0; ep < 6; ep++) begin
            ena = 1'b0; step($urandom_range(1, 3));
            train_len  = 8'($urandom_range(0, 5));
            bit_offset = 3'($urandom);
            ena = 1'b1;
            for (int c = 0; c < 40; c++) begin
                sif.s_valid = 1'($urandom_range(0, 1));
                sif.s_data  = 16'($urandom);
                bit_offset  = 3'($urandom);
                ena = ($urandom_range(0, 29) == 0) ? 1'b0 : 1'b1;
                step(1);
            end
        end

        ena = 1'b0; sif.s_valid = 1'b0; step(4);
        check("sb_drain", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
